// File: rtl/store_buffer_if.sv
// Port bundle for store_buffer: MEM-stage store/load requests and the data-memory side.
// slave is the buffer's view; master is the pipeline/memory view.
interface store_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ST_VALID;
  logic              ST_BYTE;
  logic [ADDR_W-1:0] ST_ADDR;
  logic [DATA_W-1:0] ST_DATA;
  logic              ST_READY;
  logic              LD_REQ;
  logic              LD_BYTE;
  logic [ADDR_W-1:0] LD_ADDR;
  logic              LD_HIT;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_STALL;
  logic              M_W;
  logic              M_R;
  logic              M_BYTE_EN;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_DATA;
  logic              EMPTY;

  modport slave (
    input  ST_VALID, ST_BYTE, ST_ADDR, ST_DATA,
    input  LD_REQ, LD_BYTE, LD_ADDR,
    output ST_READY, LD_HIT, LD_DATA, LD_STALL,
    output M_W, M_R, M_BYTE_EN, M_ADDR, M_DATA, EMPTY
  );

  modport master (
    output ST_VALID, ST_BYTE, ST_ADDR, ST_DATA,
    output LD_REQ, LD_BYTE, LD_ADDR,
    input  ST_READY, LD_HIT, LD_DATA, LD_STALL,
    input  M_W, M_R, M_BYTE_EN, M_ADDR, M_DATA, EMPTY
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM stage and data memory with load forwarding.
// Optional store merging into the youngest entry: define STBUF_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_W - 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              r_valid [DEPTH];
  logic [WA_W-1:0]   r_waddr [DEPTH];
  logic [1:0]        r_mask  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_match;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W-1:0]  w_idx;
  logic [1:0]        w_ld_need;
  logic              w_cover;
  logic              w_ld_miss;
  logic              w_ld_hit;
  logic              w_ld_stall;
  logic              w_pop;
  logic              w_push;
  logic              w_merge;
  logic              w_alloc;
  logic [1:0]        w_st_mask;
  logic [DATA_W-1:0] w_st_data;
  logic [1:0]        w_head_mask;
  logic [DATA_W-1:0] w_head_data;

  // Walk oldest to youngest so the last match wins (youngest store).
  always_comb begin
    w_match = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && r_valid[w_idx] &&
          (r_waddr[w_idx] == sb.LD_ADDR[ADDR_W-1:1])) begin
        w_match = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_ld_need  = sb.LD_BYTE ? (sb.LD_ADDR[0] ? 2'b10 : 2'b01) : 2'b11;
  assign w_cover    = ((r_mask[w_sel] & w_ld_need) == w_ld_need);
  assign w_ld_miss  = sb.LD_REQ & ~w_match;
  assign w_ld_hit   = sb.LD_REQ & w_match & w_cover;
  assign w_ld_stall = sb.LD_REQ & w_match & ~w_cover;

  assign w_pop  = (r_count != '0) & ~w_ld_miss;
  assign w_push = sb.ST_VALID & (r_count != FULL);

  assign w_st_mask = sb.ST_BYTE ? (sb.ST_ADDR[0] ? 2'b10 : 2'b01) : 2'b11;
  assign w_st_data = sb.ST_BYTE ? {sb.ST_DATA[7:0], sb.ST_DATA[7:0]} : sb.ST_DATA;

`ifdef STBUF_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  assign w_young = r_tail - PTR_W'(1);
  // With a single entry being popped this cycle the merge target would vanish.
  assign w_merge = w_push & (r_count != '0) & r_valid[w_young] &
                   (r_waddr[w_young] == sb.ST_ADDR[ADDR_W-1:1]) &
                   ~(w_pop & (r_count == CNT_W'(1)));
`else
  assign w_merge = 1'b0;
`endif

  assign w_alloc     = w_push & ~w_merge;
  assign w_head_mask = r_mask[r_head];
  assign w_head_data = r_data[r_head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_waddr[i] <= '0;
        r_mask[i]  <= '0;
        r_data[i]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_waddr[r_tail] <= sb.ST_ADDR[ADDR_W-1:1];
        r_mask[r_tail]  <= w_st_mask;
        r_data[r_tail]  <= w_st_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
`ifdef STBUF_COALESCE_EN
      if (w_merge) begin
        if (w_st_mask[0]) r_data[w_young][7:0]  <= w_st_data[7:0];
        if (w_st_mask[1]) r_data[w_young][15:8] <= w_st_data[15:8];
        r_mask[w_young] <= r_mask[w_young] | w_st_mask;
      end
`endif
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  assign sb.ST_READY = (r_count != FULL);
  assign sb.EMPTY    = (r_count == '0);

  // Request-driven outputs are forced quiet while reset is held.
  always_comb begin
    sb.LD_HIT    = 1'b0;
    sb.LD_STALL  = 1'b0;
    sb.LD_DATA   = '0;
    sb.M_W       = 1'b0;
    sb.M_R       = 1'b0;
    sb.M_BYTE_EN = 1'b0;
    sb.M_ADDR    = '0;
    sb.M_DATA    = '0;
    if (!rst) begin
      sb.LD_HIT   = w_ld_hit;
      sb.LD_STALL = w_ld_stall;
      if (w_ld_hit) begin
        if (!sb.LD_BYTE)
          sb.LD_DATA = r_data[w_sel];
        else if (sb.LD_ADDR[0])
          sb.LD_DATA = {8'h00, r_data[w_sel][15:8]};
        else
          sb.LD_DATA = {8'h00, r_data[w_sel][7:0]};
      end
      if (w_ld_miss) begin
        sb.M_R       = 1'b1;
        sb.M_ADDR    = sb.LD_ADDR;
        sb.M_BYTE_EN = sb.LD_BYTE;
      end else if (w_pop) begin
        sb.M_W       = 1'b1;
        sb.M_BYTE_EN = (w_head_mask != 2'b11);
        sb.M_ADDR    = {r_waddr[r_head], (w_head_mask == 2'b10)};
        if (w_head_mask == 2'b11)
          sb.M_DATA = w_head_data;
        else if (w_head_mask == 2'b10)
          sb.M_DATA = {8'h00, w_head_data[15:8]};
        else
          sb.M_DATA = {8'h00, w_head_data[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the buffer.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [14:0] wa;
    logic [1:0]  m;
    logic [15:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_drop;
  ent_t q[$];

  store_buffer_if #(.ADDR_W(16), .DATA_W(16)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ready"}, 16'(sb_if.ST_READY), 16'd1);
    chk({tag, "_empty"}, 16'(sb_if.EMPTY), 16'd1);
    chk({tag, "_mw"}, 16'(sb_if.M_W), 16'd0);
    chk({tag, "_mr"}, 16'(sb_if.M_R), 16'd0);
    chk({tag, "_hit"}, 16'(sb_if.LD_HIT), 16'd0);
    chk({tag, "_stall"}, 16'(sb_if.LD_STALL), 16'd0);
    chk({tag, "_lddata"}, sb_if.LD_DATA, 16'd0);
    chk({tag, "_maddr"}, sb_if.M_ADDR, 16'd0);
    chk({tag, "_mdata"}, sb_if.M_DATA, 16'd0);
    chk({tag, "_be"}, 16'(sb_if.M_BYTE_EN), 16'd0);
  endtask

  task automatic drive(input logic sv, input logic sbyte, input logic [15:0] sa,
                       input logic [15:0] sd, input logic lr, input logic lb,
                       input logic [15:0] la);
    sb_if.ST_VALID = sv;
    sb_if.ST_BYTE  = sbyte;
    sb_if.ST_ADDR  = sa;
    sb_if.ST_DATA  = sd;
    sb_if.LD_REQ   = lr;
    sb_if.LD_BYTE  = lb;
    sb_if.LD_ADDR  = la;
  endtask

  // One clock: drive, compare against the model, clock, advance the model.
  task automatic step(input string tag, input logic sv, input logic sbyte,
                      input logic [15:0] sa, input logic [15:0] sd,
                      input logic lr, input logic lb, input logic [15:0] la);
    ent_t        e;
    ent_t        t;
    int          hi;
    int          last;
    logic [1:0]  need;
    logic        miss, hit, stall, drain, push, merge;
    logic [15:0] e_ld, e_ma, e_md;
    logic        e_be;
    drive(sv, sbyte, sa, sd, lr, lb, la);
    #2;
    hi = -1;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].wa == la[15:1]) begin
        hi = k;
        break;
      end
    end
    need  = lb ? (la[0] ? 2'b10 : 2'b01) : 2'b11;
    miss  = lr && (hi < 0);
    hit   = lr && (hi >= 0) && ((q[hi].m & need) == need);
    stall = lr && (hi >= 0) && !hit;
    e_ld  = 16'h0;
    if (hit) begin
      if (!lb)       e_ld = q[hi].d;
      else if (la[0]) e_ld = {8'h00, q[hi].d[15:8]};
      else           e_ld = {8'h00, q[hi].d[7:0]};
    end
    drain = (q.size() > 0) && !miss;
    e_be = 1'b0;
    e_ma = 16'h0;
    e_md = 16'h0;
    if (miss) begin
      e_ma = la;
      e_be = lb;
    end else if (drain) begin
      e    = q[0];
      e_be = (e.m != 2'b11);
      e_ma = {e.wa, (e.m == 2'b10)};
      if (e.m == 2'b11)      e_md = e.d;
      else if (e.m == 2'b10) e_md = {8'h00, e.d[15:8]};
      else                   e_md = {8'h00, e.d[7:0]};
    end
    chk({tag, ":ready"}, 16'(sb_if.ST_READY), 16'(q.size() != DEPTH));
    chk({tag, ":empty"}, 16'(sb_if.EMPTY), 16'(q.size() == 0));
    chk({tag, ":hit"}, 16'(sb_if.LD_HIT), 16'(hit));
    chk({tag, ":stall"}, 16'(sb_if.LD_STALL), 16'(stall));
    chk({tag, ":lddata"}, sb_if.LD_DATA, e_ld);
    chk({tag, ":mw"}, 16'(sb_if.M_W), 16'(drain));
    chk({tag, ":mr"}, 16'(sb_if.M_R), 16'(miss));
    chk({tag, ":be"}, 16'(sb_if.M_BYTE_EN), 16'(e_be));
    chk({tag, ":maddr"}, sb_if.M_ADDR, e_ma);
    chk({tag, ":mdata"}, sb_if.M_DATA, e_md);
    @(posedge clk);
    push = sv && (q.size() < DEPTH);
    if (sv && !push) n_drop++;
    e.wa = sa[15:1];
    e.m  = sbyte ? (sa[0] ? 2'b10 : 2'b01) : 2'b11;
    e.d  = sbyte ? (sa[0] ? {sd[7:0], 8'h00} : {8'h00, sd[7:0]}) : sd;
    merge = 1'b0;
`ifdef STBUF_COALESCE_EN
    merge = push && (q.size() > 0) && (q[q.size()-1].wa == e.wa) &&
            !(drain && (q.size() == 1));
    if (merge) begin
      last = q.size() - 1;
      t = q[last];
      if (e.m[0]) t.d[7:0]  = e.d[7:0];
      if (e.m[1]) t.d[15:8] = e.d[15:8];
      t.m = t.m | e.m;
      q[last] = t;
    end
`else
    last = 0;
    t = e;
`endif
    if (drain) void'(q.pop_front());
    if (push && !merge) q.push_back(e);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_drop  = 0;
    rst = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    #3;
    reset_chk("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word store drains on the next idle cycle.
    step("ws_push", 1, 0, 16'h0002, 16'h1234, 0, 0, 16'h0);
    chk("ws_drain_data", sb_if.M_DATA, 16'h1234);
    chk("ws_drain_addr", sb_if.M_ADDR, 16'h0002);
    step("ws_drain", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    step("ws_after", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Fill while miss loads hold the memory port, then overflow attempt.
    for (int k = 0; k < 4; k++)
      step("fill", 1, 0, 16'(16'h0010 + 2*k), 16'(16'hA000 + k), 1, 0, 16'h0100);
    chk("full_ready", 16'(sb_if.ST_READY), 16'd0);
    step("fill5", 1, 0, 16'h0040, 16'hDEAD, 1, 0, 16'h0100);
    chk("fill5_dropped", 16'(n_drop), 16'd1);
    for (int k = 0; k < 5; k++)
      step("fill_drain", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Word forward.
    step("fw_push", 1, 0, 16'h0004, 16'hAAAA, 0, 0, 16'h0);
    step("fw_load", 0, 0, 16'h0, 16'h0, 1, 0, 16'h0004);
    step("fw_idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Byte forward, then partial-overlap stall until the byte entry retires.
    step("bf_old", 1, 0, 16'h0020, 16'hBEEF, 1, 0, 16'h0100);
    step("bf_push", 1, 1, 16'h0005, 16'h0055, 1, 0, 16'h0100);
    step("bf_load", 0, 0, 16'h0, 16'h0, 1, 1, 16'h0005);
    for (int k = 0; k < 3; k++)
      step("stall_ld", 0, 0, 16'h0, 16'h0, 1, 0, 16'h0004);
    chk("stall_resolved_mr", 16'(sb_if.M_R), 16'd1);
    step("stall_idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Byte pair to one word while the drain is blocked.
    step("co_b0", 1, 1, 16'h0006, 16'h0011, 1, 0, 16'h0100);
    step("co_b1", 1, 1, 16'h0007, 16'h0022, 1, 0, 16'h0100);
    for (int k = 0; k < 3; k++)
      step("co_drain", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Reset asserted mid-drain with three entries held.
    for (int k = 0; k < 3; k++)
      step("rs_fill", 1, 0, 16'(16'h0030 + 2*k), 16'(16'h5000 + k), 1, 0, 16'h0100);
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    #2;
    chk("rs_pre_mw", 16'(sb_if.M_W), 16'd1);
    rst = 1'b1;
    #1;
    reset_chk("mid");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      step("rs_after", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Random traffic over a small address window to provoke hits and stalls.
    for (int k = 0; k < 400; k++) begin
      logic        sv, sbyte, lr, lb;
      logic [15:0] sa, sd, la;
      sv    = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
      sbyte = $urandom_range(0, 1) == 1;
      sa    = 16'($urandom_range(0, 15));
      sd    = 16'($urandom);
      lr    = $urandom_range(0, 2) == 0;
      lb    = $urandom_range(0, 1) == 1;
      la    = ($urandom_range(0, 7) == 0) ? 16'h0200 : 16'($urandom_range(0, 15));
      step("rnd", sv, sbyte, sa, sd, lr, lb, la);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
